dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for a DDS.
// On start it walks a tuning word from a start value to a stop value in
// fixed increments, and holds each word for a programmable number of cycles.
// The last step is clamped to the stop word. The sweep runs once, or it
// repeats until it is aborted.
module dds_sweep_ctrl #(
  parameter int FREQ_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   continuous_i,
  input  logic [FREQ_WIDTH-1:0]  start_freq_i,
  input  logic [FREQ_WIDTH-1:0]  stop_freq_i,
  input  logic [FREQ_WIDTH-1:0]  step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output logic [FREQ_WIDTH-1:0]  freq_o,
  output logic                   busy_o,
  output logic                   step_o,
  output logic                   done_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DWELL = 1'b1;

  logic [0:0]             state;
  logic [FREQ_WIDTH-1:0]  freq;
  logic [FREQ_WIDTH-1:0]  cfg_start;
  logic [FREQ_WIDTH-1:0]  cfg_stop;
  logic [FREQ_WIDTH-1:0]  cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic                   cfg_cont;
  logic                   cfg_up;
  logic                   step_pulse;
  logic                   done_pulse;
  logic                   dwell_end;
  logic                   at_stop;

  // Next tuning word, clamped to the stop word. A step that would carry out
  // or pass the stop word lands exactly on stop. A zero step jumps straight
  // to stop, so a zero step cannot stall the sweep.
  function automatic logic [FREQ_WIDTH-1:0] next_word(
    input logic [FREQ_WIDTH-1:0] cur,
    input logic [FREQ_WIDTH-1:0] stop,
    input logic [FREQ_WIDTH-1:0] step,
    input logic                  up
  );
    logic [FREQ_WIDTH:0]   sum;
    logic [FREQ_WIDTH-1:0] gap;
    sum = {1'b0, cur} + {1'b0, step};
    gap = cur - stop;
    if (step == '0)
      next_word = stop;
    else if (up)
      next_word = (sum[FREQ_WIDTH] || (sum[FREQ_WIDTH-1:0] > stop)) ? stop : sum[FREQ_WIDTH-1:0];
    else
      next_word = (step > gap) ? stop : cur - step;
  endfunction

  // Terminal conditions of the current dwell
  always_comb begin
    dwell_end = (dwell_cnt == cfg_dwell - DWELL_WIDTH'(1));
    at_stop   = (freq == cfg_stop);
  end

  // Sweep state machine; abort has priority over start and over dwell completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      freq       <= '0;
      dwell_cnt  <= '0;
      cfg_start  <= '0;
      cfg_stop   <= '0;
      cfg_step   <= '0;
      cfg_dwell  <= '0;
      cfg_cont   <= 1'b0;
      cfg_up     <= 1'b0;
      step_pulse <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      done_pulse <= 1'b0;
      if (abort_i) begin
        state     <= IDLE;
        freq      <= '0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              cfg_start  <= start_freq_i;
              cfg_stop   <= stop_freq_i;
              cfg_step   <= step_i;
              cfg_dwell  <= (dwell_i == '0) ? DWELL_WIDTH'(1) : dwell_i;
              cfg_cont   <= continuous_i;
              cfg_up     <= (stop_freq_i >= start_freq_i);
              freq       <= start_freq_i;
              dwell_cnt  <= '0;
              step_pulse <= 1'b1;
              state      <= DWELL;
            end
          end
          DWELL: begin
            if (dwell_end) begin
              dwell_cnt <= '0;
              if (at_stop) begin
                if (cfg_cont) begin
                  freq       <= cfg_start;
                  step_pulse <= 1'b1;
                end else begin
                  state      <= IDLE;
                  done_pulse <= 1'b1;
                end
              end else begin
                freq       <= next_word(freq, cfg_stop, cfg_step, cfg_up);
                step_pulse <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    freq_o = freq;
    busy_o = (state == DWELL);
    step_o = step_pulse;
    done_o = done_pulse;
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl. The expected sequences are written out by hand.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic        continuous_i;
  logic [31:0] start_freq_i;
  logic [31:0] stop_freq_i;
  logic [31:0] step_i;
  logic [15:0] dwell_i;
  logic [31:0] freq_o;
  logic        busy_o;
  logic        step_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .FREQ_WIDTH (32),
    .DWELL_WIDTH(16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .continuous_i(continuous_i),
    .start_freq_i(start_freq_i),
    .stop_freq_i (stop_freq_i),
    .step_i      (step_i),
    .dwell_i     (dwell_i),
    .freq_o      (freq_o),
    .busy_o      (busy_o),
    .step_o      (step_o),
    .done_o      (done_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the outputs of the current cycle, then advance one cycle
  task automatic expect_cyc(input string tag, input logic [31:0] f, input logic s,
                            input logic b, input logic d);
    check_eq({tag, " freq"}, 64'(freq_o), 64'(f));
    check_eq({tag, " step"}, 64'(step_o), 64'(s));
    check_eq({tag, " busy"}, 64'(busy_o), 64'(b));
    check_eq({tag, " done"}, 64'(done_o), 64'(d));
    tick();
  endtask

  // Start a sweep. Afterwards the config inputs are scrambled, so any use of
  // them past the accepting edge shows up as a wrong value.
  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [15:0] dw, input logic c);
    start_freq_i = s;
    stop_freq_i  = e;
    step_i       = st;
    dwell_i      = dw;
    continuous_i = c;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
    start_freq_i = 32'hDEAD_BEEF;
    stop_freq_i  = 32'h0000_1234;
    step_i       = 32'd7;
    dwell_i      = 16'd9;
    continuous_i = ~c;
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    continuous_i = 1'b0;
    start_freq_i = '0;
    stop_freq_i = '0;
    step_i = '0;
    dwell_i = '0;
    tick();
    tick();
    expect_cyc("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    expect_cyc("idle after reset", 32'd0, 1'b0, 1'b0, 1'b0);

    // Up sweep, 3-cycle dwell. start_i stays asserted while busy and must be ignored.
    start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
    start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (k == 3 && d == 0) start_i = 1'b0;
        expect_cyc($sformatf("up k%0d d%0d", k, d), 32'd100 + 32'(10 * k), d == 0, 1'b1, 1'b0);
      end
    end
    expect_cyc("up done", 32'd130, 1'b0, 1'b0, 1'b1);
    expect_cyc("up idle hold", 32'd130, 1'b0, 1'b0, 1'b0);

    // Down sweep with the last step clamped; dwell 0 acts as 1
    start_sweep(32'd50, 32'd0, 32'd20, 16'd0, 1'b0);
    expect_cyc("down 50", 32'd50, 1'b1, 1'b1, 1'b0);
    expect_cyc("down 30", 32'd30, 1'b1, 1'b1, 1'b0);
    expect_cyc("down 10", 32'd10, 1'b1, 1'b1, 1'b0);
    expect_cyc("down 0", 32'd0, 1'b1, 1'b1, 1'b0);
    expect_cyc("down done", 32'd0, 1'b0, 1'b0, 1'b1);
    expect_cyc("down idle", 32'd0, 1'b0, 1'b0, 1'b0);

    // Carry-out clamps to stop
    start_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd2, 1'b0);
    expect_cyc("ovf a0", 32'hFFFF_FF00, 1'b1, 1'b1, 1'b0);
    expect_cyc("ovf a1", 32'hFFFF_FF00, 1'b0, 1'b1, 1'b0);
    expect_cyc("ovf b0", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    expect_cyc("ovf b1", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    expect_cyc("ovf done", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

    // A zero step jumps straight to stop
    start_sweep(32'd10, 32'd40, 32'd0, 16'd1, 1'b0);
    expect_cyc("step0 start", 32'd10, 1'b1, 1'b1, 1'b0);
    expect_cyc("step0 stop", 32'd40, 1'b1, 1'b1, 1'b0);
    expect_cyc("step0 done", 32'd40, 1'b0, 1'b0, 1'b1);

    // start together with abort in IDLE: stays idle, freq cleared
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    expect_cyc("start+abort idle", 32'd0, 1'b0, 1'b0, 1'b0);

    // Continuous sweep, then an abort while freq is 1
    start_sweep(32'd0, 32'd2, 32'd1, 16'd1, 1'b1);
    for (int i = 0; i < 4; i++)
      expect_cyc($sformatf("cont %0d", i), 32'(i % 3), 1'b1, 1'b1, 1'b0);
    abort_i = 1'b1;
    expect_cyc("cont 4", 32'd1, 1'b1, 1'b1, 1'b0);
    abort_i = 1'b0;
    expect_cyc("abort", 32'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("abort idle", 32'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a sweep, then a fresh sweep with start == stop
    start_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
    expect_cyc("pre-rst 0", 32'd100, 1'b1, 1'b1, 1'b0);
    rst_i = 1'b1;
    expect_cyc("pre-rst 1", 32'd100, 1'b0, 1'b1, 1'b0);
    rst_i = 1'b0;
    expect_cyc("after rst", 32'd0, 1'b0, 1'b0, 1'b0);
    start_sweep(32'd5, 32'd5, 32'd3, 16'd2, 1'b0);
    expect_cyc("eq 0", 32'd5, 1'b1, 1'b1, 1'b0);
    expect_cyc("eq 1", 32'd5, 1'b0, 1'b1, 1'b0);
    expect_cyc("eq done", 32'd5, 1'b0, 1'b0, 1'b1);
    expect_cyc("eq idle", 32'd5, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
